// File: rtl/uart_pkg.sv
// uart_pkg: UART register map, CTRL/CTRL_INT bit positions, sequencer state encoding and byte builders.
package uart_pkg;
  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_INT  = 3'd1;
  localparam logic [2:0] ADDR_SEND = 3'd2;
  localparam logic [2:0] ADDR_RECV = 3'd3;
  localparam int CTRL_TX_START = 7;
  localparam int CTRL_RX_EN    = 6;
  localparam int INT_RX_DONE   = 7;
  localparam int INT_RX_ERR    = 6;
  localparam int INT_TX_DONE   = 5;
  localparam logic [2:0] CFG_CTRL  = 3'd0;
  localparam logic [2:0] CFG_INT   = 3'd1;
  localparam logic [2:0] IDLE      = 3'd2;
  localparam logic [2:0] RD_RX     = 3'd3;
  localparam logic [2:0] LOAD_SEND = 3'd4;
  localparam logic [2:0] START     = 3'd5;
  localparam logic [2:0] WAIT_DONE = 3'd6;
  localparam logic [2:0] CLR_START = 3'd7;
  function automatic logic [7:0] ctrl_byte(input logic start, input logic rx_en,
                                           input logic [2:0] baud, input logic [2:0] size);
    logic [7:0] v;
    v = {2'b00, baud, size};
    v[CTRL_TX_START] = start;
    v[CTRL_RX_EN] = rx_en;
    return v;
  endfunction
  function automatic logic [7:0] int_byte(input logic rx_en);
    logic [7:0] v;
    v = '0;
    v[INT_RX_DONE] = rx_en;
    v[INT_RX_ERR] = rx_en;
    v[INT_TX_DONE] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/uart_seq_fifo.sv
// uart_seq_fifo: power-of-two byte FIFO with wrapping pointers and a separate occupancy count.
module uart_seq_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/uart_sequencer.sv
// uart_sequencer: configures a register-mapped UART, streams buffered TX bytes and collects RX bytes.
// RX path (RD_RX state, rx_valid/rx_err/rx_data) is built only when UART_SEQ_RX_EN is defined.
module uart_sequencer
  import uart_pkg::*;
#(
  parameter logic [2:0] BAUD_SEL = 3'b100,
  parameter logic [2:0] SIZE_SEL = 3'b100,
  parameter int HOLD_CYCLES = 2,
  parameter int TX_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       busy,
  output logic       tx_timeout,
  output logic       uart_enable,
  output logic       uart_write_enable,
  output logic [2:0] uart_address,
  output logic [7:0] uart_write_data,
  input  logic [7:0] uart_read_data,
  input  logic       rx_data_int,
  input  logic       tx_done_int,
  input  logic       rx_error_int
);
`ifdef UART_SEQ_RX_EN
  localparam logic RX_EN_BIT = 1'b1;
`else
  localparam logic RX_EN_BIT = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT_CYCLES + HOLD_CYCLES + 1);
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic run_q, tx_timeout_q, last, tmo, pop, rx_pend, fifo_full, fifo_empty;
  logic [7:0] head;
  uart_seq_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(tx_valid), .data_i(tx_data), .pop_i(pop),
    .data_o(head), .full_o(fifo_full), .empty_o(fifo_empty)
  );
  assign last = cnt_q == CW'(HOLD_CYCLES - 1);
  assign tmo = state_q == WAIT_DONE && !tx_done_int && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign pop = state_q == LOAD_SEND && last;
  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG_CTRL:  state_d = run_q && last ? CFG_INT : CFG_CTRL;
      CFG_INT:   state_d = last ? IDLE : CFG_INT;
      IDLE:      state_d = rx_pend ? RD_RX : !fifo_empty ? LOAD_SEND : IDLE;
      RD_RX:     state_d = last ? IDLE : RD_RX;
      LOAD_SEND: state_d = last ? START : LOAD_SEND;
      START:     state_d = last ? WAIT_DONE : START;
      WAIT_DONE: state_d = tx_done_int || tmo ? CLR_START : WAIT_DONE;
      default:   state_d = last ? IDLE : CLR_START;
    endcase
  end
  // run_q keeps the bus quiet on the first clock after reset so every access is fully held
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= CFG_CTRL;
      cnt_q <= '0;
      run_q <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      state_q <= state_d;
      cnt_q <= (state_d != state_q || !run_q) ? '0 : cnt_q + CW'(1);
      tx_timeout_q <= tmo;
    end
  assign tx_ready = !fifo_full;
  assign busy = state_q != IDLE || !fifo_empty;
  assign tx_timeout = tx_timeout_q;
  assign uart_enable = run_q && state_q != IDLE && state_q != WAIT_DONE;
  assign uart_write_enable = uart_enable && state_q != RD_RX;
  assign uart_address = !uart_enable ? ADDR_CTRL : state_q == CFG_INT ? ADDR_INT :
                        state_q == RD_RX ? ADDR_RECV : state_q == LOAD_SEND ? ADDR_SEND : ADDR_CTRL;
  assign uart_write_data = !uart_write_enable ? 8'h00 : state_q == CFG_INT ? int_byte(RX_EN_BIT) :
                           state_q == LOAD_SEND ? head : ctrl_byte(state_q == START, RX_EN_BIT, BAUD_SEL, SIZE_SEL);
`ifdef UART_SEQ_RX_EN
  logic rxd_prev_q, rxe_prev_q, rx_pend_q, err_pend_q, rx_valid_q, rx_err_q;
  logic [7:0] rx_data_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rxd_prev_q <= 1'b0;
      rxe_prev_q <= 1'b0;
      rx_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      rxd_prev_q <= rx_data_int;
      rxe_prev_q <= rx_error_int;
      rx_pend_q <= (rx_data_int && !rxd_prev_q) || (rx_pend_q && !(state_q == RD_RX && last));
      err_pend_q <= rx_error_int && !rxe_prev_q;
      rx_err_q <= err_pend_q;
      rx_valid_q <= state_q == RD_RX && last;
      if (state_q == RD_RX && last) rx_data_q <= uart_read_data;
    end
  assign rx_pend = rx_pend_q;
  assign rx_valid = rx_valid_q;
  assign rx_err = rx_err_q;
  assign rx_data = rx_data_q;
`else
  logic unused_rx;
  assign unused_rx = ^{rx_data_int, rx_error_int, uart_read_data};
  assign rx_pend = 1'b0;
  assign rx_valid = 1'b0;
  assign rx_err = 1'b0;
  assign rx_data = 8'h00;
`endif
endmodule

// File: tb/tb_uart_sequencer.sv
// tb_uart_sequencer: scoreboard bench; expected UART bus accesses are queued as stimulus is applied.
module tb_uart_sequencer;
  localparam int HOLD = 2;
`ifdef UART_SEQ_RX_EN
  localparam logic RXB = 1'b1;
`else
  localparam logic RXB = 1'b0;
`endif
  localparam logic [7:0] CTRL_OFF = {1'b0, RXB, 3'b100, 3'b100};
  localparam logic [7:0] CTRL_GO  = {1'b1, RXB, 3'b100, 3'b100};
  localparam logic [7:0] INT_V    = {RXB, RXB, 1'b1, 5'b00000};
  typedef struct packed {logic we; logic [2:0] a; logic [7:0] d;} acc_t;
  logic clk = 0, rst = 0, tx_valid = 0, rx_data_int = 0, rx_error_int = 0, tx_done_int;
  logic [7:0] tx_data = 0, uart_read_data = 0;
  logic tx_ready, rx_valid, rx_err, busy, tx_timeout, uart_enable, uart_write_enable;
  logic [7:0] rx_data, uart_write_data;
  logic [2:0] uart_address;
  acc_t exp_q[$];
  acc_t cur, now_t, e;
  logic cur_v = 0, auto_done = 0, armed = 0;
  int len = 0, n_vec = 0, n_err = 0;

  uart_sequencer dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .busy(busy), .tx_timeout(tx_timeout),
    .uart_enable(uart_enable), .uart_write_enable(uart_write_enable), .uart_address(uart_address),
    .uart_write_data(uart_write_data), .uart_read_data(uart_read_data),
    .rx_data_int(rx_data_int), .tx_done_int(tx_done_int), .rx_error_int(rx_error_int)
  );

  initial forever #5 clk = ~clk;

  // bus monitor: a completed access is compared against the head of the expected queue
  initial forever begin
    @(negedge clk);
    now_t = {uart_write_enable, uart_address, uart_write_data};
    if (uart_enable && cur_v && now_t == cur) len++;
    else begin
      if (cur_v) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bus_unexpected got we=%0b addr=%0d data=%h, required no access", cur.we, cur.a, cur.d);
        end else begin
          e = exp_q.pop_front();
          if (cur.we !== e.we || cur.a !== e.a || (e.we && cur.d !== e.d) || len !== HOLD) begin
            n_err++;
            $display("FAIL bus_access got we=%0b addr=%0d data=%h len=%0d, required we=%0b addr=%0d data=%h len=%0d",
                     cur.we, cur.a, cur.d, len, e.we, e.a, e.d, HOLD);
          end
        end
      end
      cur_v = uart_enable;
      cur = now_t;
      len = 1;
    end
  end

  // UART model: one tx_done_int pulse after a TX_START write, when allowed
  initial begin
    tx_done_int = 0;
    forever begin
      @(negedge clk);
      tx_done_int = 0;
      if (!rst) armed = 0;
      else if (uart_enable && uart_write_enable && uart_address == 3'd0 && uart_write_data[7]) armed = 1;
      else if (uart_enable && uart_write_enable && uart_address == 3'd0) armed = 0;
      else if (armed && auto_done) begin
        tx_done_int = 1;
        armed = 0;
      end
    end
  end

  task automatic exp_cfg;
    exp_q.push_back({1'b1, 3'd0, CTRL_OFF});
    exp_q.push_back({1'b1, 3'd1, INT_V});
  endtask

  task automatic exp_send(input logic [7:0] b);
    exp_q.push_back({1'b1, 3'd2, b});
    exp_q.push_back({1'b1, 3'd0, CTRL_GO});
    exp_q.push_back({1'b1, 3'd0, CTRL_OFF});
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1;
    tx_data = b;
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic wait_exp(input int left, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() <= left) break;
    end
    n_vec++;
    if (exp_q.size() > left) begin
      n_err++;
      $display("FAIL %s_wait got %0d accesses outstanding, required %0d", tag, exp_q.size(), left);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && !cur_v) break;
    end
    n_vec++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle got outstanding=%0d busy=%b, required 0 and 0", tag, exp_q.size(), busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if ({uart_enable, uart_write_enable, uart_address, uart_write_data, rx_valid, rx_err, rx_data, tx_timeout, tx_ready, busy}
        !== {1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL %s got en=%b we=%b a=%0d d=%h rxv=%b rxe=%b rxd=%h tmo=%b rdy=%b busy=%b, required all 0 except rdy=1 busy=1",
               tag, uart_enable, uart_write_enable, uart_address, uart_write_data, rx_valid, rx_err, rx_data,
               tx_timeout, tx_ready, busy);
    end
  endtask

  task automatic test_reset;
    rst = 0;
    #1;
    check_reset_outputs("reset_outputs");
    exp_cfg();
    @(negedge clk);
    rst = 1;
    wait_idle(100, "reset_cfg");
    n_vec++;
    if (tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b, required 1", tx_ready);
    end
  endtask

  task automatic test_single;
    auto_done = 1;
    exp_send(8'hAB);
    push(8'hAB);
    wait_idle(200, "single");
  endtask

  task automatic test_fill;
    auto_done = 0;
    exp_send(8'h10);
    push(8'h10);
    wait_exp(1, 100, "fill_first");
    for (int i = 0; i < 4; i++) exp_send(8'h11 + 8'(i));
    tx_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'h11 + 8'(i);
      @(negedge clk);
      n_vec++;
      if (tx_ready !== (i < 3)) begin
        n_err++;
        $display("FAIL fill_ready push=%0d got %b, required %b", i + 1, tx_ready, i < 3);
      end
    end
    tx_valid = 0;
    auto_done = 1;
    wait_idle(600, "fill_drain");
  endtask

  task automatic test_rx;
    int seen;
    int got;
`ifdef UART_SEQ_RX_EN
    auto_done = 0;
    exp_send(8'h33);
    exp_q.push_back({1'b0, 3'd3, 8'h00});
    push(8'h33);
    wait_exp(2, 100, "rx_tx");
    uart_read_data = 8'h5A;
    rx_data_int = 1;
    @(negedge clk);
    rx_data_int = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rx_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rx_early got %0d rx_valid cycles during TX, required 0", seen);
    end
    auto_done = 1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        got = 1;
        break;
      end
    end
    n_vec++;
    if (got != 1 || rx_data !== 8'h5A) begin
      n_err++;
      $display("FAIL rx_capture got valid=%0d data=%h, required 1 and 5a", got, rx_data);
    end
    @(negedge clk);
    n_vec++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h5A) begin
      n_err++;
      $display("FAIL rx_pulse got valid=%b data=%h, required 0 and 5a", rx_valid, rx_data);
    end
    wait_idle(100, "rx");
    rx_error_int = 1;
    @(negedge clk);
    rx_error_int = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rx_err) seen++;
    end
    n_vec++;
    if (seen != 1) begin
      n_err++;
      $display("FAIL rx_err_pulse got %0d cycles, required 1", seen);
    end
`else
    got = 0;
    rx_data_int = 1;
    rx_error_int = 1;
    @(negedge clk);
    rx_data_int = 0;
    rx_error_int = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rx_valid || rx_err || rx_data !== 8'h00) seen++;
    end
    n_vec++;
    if (seen != got) begin
      n_err++;
      $display("FAIL rx_disabled got %0d active cycles, required 0", seen);
    end
`endif
    wait_idle(50, "rx_end");
  endtask

  task automatic test_timeout;
    int n;
    auto_done = 0;
    exp_send(8'h41);
    exp_send(8'h42);
    push(8'h41);
    push(8'h42);
    wait_exp(4, 100, "timeout_start");
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n++;
      if (tx_timeout) break;
    end
    n_vec++;
    if (n != 2048 || tx_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_cycles got %0d (pulse=%b), required 2048 (pulse=1)", n, tx_timeout);
    end
    auto_done = 1;
    @(negedge clk);
    n_vec++;
    if (tx_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_pulse got %b, required 0", tx_timeout);
    end
    wait_idle(200, "timeout_next");
  endtask

  task automatic test_back_to_back;
    auto_done = 1;
    for (int i = 0; i < 4; i++) exp_send(8'hC1 + 8'(i));
    @(negedge clk);
    tx_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'hC1 + 8'(i);
      @(negedge clk);
      n_vec++;
      if (tx_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready push=%0d got %b, required 1", i + 1, tx_ready);
      end
    end
    tx_valid = 0;
    wait_idle(400, "b2b");
  endtask

  task automatic test_reset_mid;
    auto_done = 0;
    exp_q.push_back({1'b1, 3'd2, 8'h77});
    exp_q.push_back({1'b1, 3'd0, CTRL_GO});
    push(8'h77);
    push(8'h78);
    wait_exp(0, 100, "mid_start");
    repeat (3) @(negedge clk);
    #2 rst = 0;
    #1;
    check_reset_outputs("mid_reset_outputs");
    exp_cfg();
    @(negedge clk);
    rst = 1;
    auto_done = 1;
    wait_idle(100, "mid_cfg");
    repeat (20) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL mid_fifo_empty got busy=%b outstanding=%0d, required 0 and 0", busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_rx();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
